// File: rtl/tvip_clock_enable_ctrl_if.sv
// Control/status bundle for the divided-clock controller.
// The master side (config/test logic) drives the requests and reads the status;
// the slave side (the controller) does the opposite.
interface tvip_clock_enable_ctrl_if #(
    parameter int COUNTER_WIDTH = 8
);
    logic                     i_start;
    logic                     i_stop;
    logic [COUNTER_WIDTH-1:0] i_half_period;
    logic                     i_period_update;
    logic                     o_clk_div;
    logic                     o_rise;
    logic                     o_fall;
    logic                     o_running;
    logic                     o_rst_n;
    logic                     o_error;

    modport master (
        output i_start, i_stop, i_half_period, i_period_update,
        input  o_clk_div, o_rise, o_fall, o_running, o_rst_n, o_error
    );

    modport slave (
        input  i_start, i_stop, i_half_period, i_period_update,
        output o_clk_div, o_rise, o_fall, o_running, o_rst_n, o_error
    );
endinterface

// File: rtl/tvip_clock_enable_ctrl.sv
// Programmable clock divider with start/stop/period-change control and a
// sequenced downstream reset. All waveform changes happen only when the
// half-period down-counter expires, so the divided clock never glitches.
module tvip_clock_enable_ctrl #(
    parameter int COUNTER_WIDTH = 8,
    parameter int RESET_CYCLES  = 4
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    tvip_clock_enable_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    localparam logic [3:0]               RC_MAX = 4'(RESET_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] ONE    = COUNTER_WIDTH'(1);

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] active_q, active_d;
    logic [COUNTER_WIDTH-1:0] pend_q, pend_d;
    logic                     pend_vld_q, pend_vld_d;
    logic [3:0]               rst_cnt_q, rst_cnt_d;
    logic                     clk_q, clk_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;
    logic                     rstn_q, rstn_d;
    logic                     err_q, err_d;
    logic                     boundary;

    assign boundary = (cnt_q == '0);

    // State and output registers; reset aborts any run with no drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            rst_cnt_q  <= '0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rstn_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            rst_cnt_q  <= rst_cnt_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rstn_q     <= rstn_d;
            err_q      <= err_d;
        end
    end

    // Next-state: start/stop sequencing, half-period counting, pending period swap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        rst_cnt_d  = rst_cnt_q;
        clk_d      = clk_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Stop has priority over start; update is ignored here.
                if (bus.i_start && !bus.i_stop) begin
                    if (bus.i_half_period == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        active_d  = bus.i_half_period;
                        cnt_d     = bus.i_half_period - ONE;
                        rst_cnt_d = '0;
                    end
                end
            end
            RUN, DRAIN: begin
                cnt_d = cnt_q - ONE;
                if (boundary) begin
                    if (state_q == DRAIN) begin
                        // Finish on a complete low phase; only fall if currently high.
                        if (clk_q) begin
                            clk_d  = 1'b0;
                            fall_d = 1'b1;
                        end
                        state_d    = IDLE;
                        cnt_d      = '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        clk_d  = ~clk_q;
                        rise_d = ~clk_q;
                        fall_d = clk_q;
                        if (!clk_q && rst_cnt_q != RC_MAX)
                            rst_cnt_d = rst_cnt_q + 4'd1;
                        if (pend_vld_q) begin
                            cnt_d      = pend_q - ONE;
                            active_d   = pend_q;
                            pend_vld_d = 1'b0;
                        end else begin
                            cnt_d = active_q - ONE;
                        end
                    end
                end
                // Evaluated after the swap so a same-cycle update waits for the next boundary.
                if (bus.i_period_update) begin
                    if (bus.i_half_period == '0) begin
                        err_d = 1'b1;
                    end else if (state_d != IDLE) begin
                        pend_d     = bus.i_half_period;
                        pend_vld_d = 1'b1;
                    end
                end
                if (state_q == RUN && bus.i_stop)
                    state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase

        // Released one cycle after the last required rise; a fresh run starts from a cleared count.
        rstn_d = (state_q != IDLE) && (state_d != IDLE) && (rst_cnt_q == RC_MAX);
    end

    assign bus.o_clk_div = clk_q;
    assign bus.o_rise    = rise_q;
    assign bus.o_fall    = fall_q;
    assign bus.o_running = (state_q != IDLE);
    assign bus.o_rst_n   = rstn_q;
    assign bus.o_error   = err_q;
endmodule

// File: tb/tb_tvip_clock_enable_ctrl.sv
// Bench for tvip_clock_enable_ctrl: directed scenarios with hand-derived
// waveforms plus a randomized run checked against an event-level model.
module tb_tvip_clock_enable_ctrl;
    localparam int CW = 8;
    localparam int RC = 4;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   checks = 0;
    int   errors = 0;

    tvip_clock_enable_ctrl_if #(.COUNTER_WIDTH(CW)) bus();

    tvip_clock_enable_ctrl #(.COUNTER_WIDTH(CW), .RESET_CYCLES(RC)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // {clk_div, rise, fall, running, rst_n, error}
    function automatic logic [5:0] obs();
        return {bus.o_clk_div, bus.o_rise, bus.o_fall, bus.o_running, bus.o_rst_n, bus.o_error};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        bus.i_period_update = 1'b0;
        bus.i_half_period = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic start_run(input int half);
        bus.i_start = 1'b1;
        bus.i_half_period = CW'(half);
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        #2;
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", obs(), 6'b0);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp %b", obs(), 6'b0);
        end
    endtask

    task automatic test_basic();
        logic [5:0] exp;
        logic c;
        do_reset();
        start_run(3);
        checks++;
        if (obs() !== 6'b000100) begin
            errors++;
            $display("FAIL basic_enter_run got %b exp %b", obs(), 6'b000100);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            c = ((n / 3) % 2) == 1;
            exp = {c, (n % 3 == 0) && c, (n % 3 == 0) && !c, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL basic_half3 n=%0d got %b exp %b", n, obs(), exp);
            end
        end
    endtask

    task automatic test_div2_and_async_reset();
        logic [5:0] exp;
        do_reset();
        start_run(1);
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {n % 2 == 1, n % 2 == 1, n % 2 == 0, 1'b1, n >= 8, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL div2 n=%0d got %b exp %b", n, obs(), exp);
            end
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_midrun got %b exp %b", obs(), 6'b0);
        end
        tick();
        tick();
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL held_in_reset got %b exp %b", obs(), 6'b0);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_period_update();
        logic [5:0] exp;
        logic c, prev;
        do_reset();
        start_run(5);
        prev = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n < 5)       c = 1'b0;
            else if (n < 10) c = 1'b1;
            else             c = (((n - 10) / 2) % 2) == 1;
            exp = {c, c && !prev, !c && prev, 1'b1, n >= 21, n == 18};
            prev = c;
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL period_update n=%0d got %b exp %b", n, obs(), exp);
            end
            bus.i_period_update = (n == 6) || (n == 17);
            bus.i_half_period = (n == 6) ? CW'(2) : '0;
        end
        idle_inputs();
    endtask

    task automatic test_stop();
        logic [5:0] exp;
        do_reset();
        start_run(4);
        for (int n = 1; n <= 9; n++) begin
            tick();
            exp = {n >= 4 && n <= 7, n == 4, n == 8, n <= 7, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL stop_high n=%0d got %b exp %b", n, obs(), exp);
            end
            bus.i_stop = (n == 6);
        end
        start_run(2);
        for (int n = 1; n <= 7; n++) begin
            tick();
            exp = {n == 2 || n == 3, n == 2, n == 4, n <= 5, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL stop_low n=%0d got %b exp %b", n, obs(), exp);
            end
            bus.i_stop = (n == 4);
        end
    endtask

    task automatic test_illegal_requests();
        logic [5:0] exp;
        logic c;
        do_reset();
        start_run(0);
        checks++;
        if (obs() !== 6'b000001) begin
            errors++;
            $display("FAIL start_zero_error got %b exp %b", obs(), 6'b000001);
        end
        tick();
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL start_zero_idle got %b exp %b", obs(), 6'b0);
        end
        bus.i_stop = 1'b1;
        start_run(3);
        bus.i_stop = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL start_stop_same got %b exp %b", obs(), 6'b0);
        end
        start_run(3);
        bus.i_start = 1'b1;
        bus.i_half_period = CW'(7);
        for (int n = 1; n <= 7; n++) begin
            tick();
            idle_inputs();
            c = ((n / 3) % 2) == 1;
            exp = {c, (n % 3 == 0) && c, (n % 3 == 0) && !c, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL start_while_running n=%0d got %b exp %b", n, obs(), exp);
            end
        end
    endtask

    task automatic test_short_run_restart();
        do_reset();
        start_run(2);
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (bus.o_rst_n !== 1'b0 || bus.o_running !== (n <= 7)) begin
                errors++;
                $display("FAIL short_run n=%0d got rst_n=%b run=%b exp rst_n=0 run=%b",
                         n, bus.o_rst_n, bus.o_running, n <= 7);
            end
            bus.i_stop = (n == 6);
        end
        start_run(255);
        for (int n = 1; n <= 255; n++) begin
            tick();
            if (n == 254 || n == 255) begin
                checks++;
                if (bus.o_clk_div !== (n == 255) || bus.o_rise !== (n == 255)) begin
                    errors++;
                    $display("FAIL half255 n=%0d got clk=%b rise=%b exp %b",
                             n, bus.o_clk_div, bus.o_rise, n == 255);
                end
            end
        end
    endtask

    // Reference: tracks cycles left to the next toggle and a last-wins pending queue.
    task automatic test_random();
        bit m_on = 0, m_dr = 0, m_lvl = 0, m_rise, m_fall, m_err, m_rstn = 0;
        int m_left = 0, m_half = 0, m_rises = 0;
        int m_pend[$];
        bit s, p, u;
        int h, had_pend, prev_rises;
        logic [5:0] exp;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s = $urandom_range(0, 9) == 0;
            p = $urandom_range(0, 29) == 0;
            u = $urandom_range(0, 11) == 0;
            h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            bus.i_start = s;
            bus.i_stop = p;
            bus.i_period_update = u;
            bus.i_half_period = CW'(h);
            tick();
            m_rise = 0; m_fall = 0; m_err = 0;
            if (!m_on) begin
                m_rstn = 0;
                if (s && !p) begin
                    if (h == 0) m_err = 1;
                    else begin
                        m_on = 1; m_dr = 0; m_lvl = 0;
                        m_half = h; m_left = h; m_rises = 0;
                        m_pend.delete();
                    end
                end
            end else begin
                had_pend = m_pend.size();
                prev_rises = m_rises;
                m_left--;
                if (m_left == 0) begin
                    if (m_dr) begin
                        if (m_lvl) begin m_lvl = 0; m_fall = 1; end
                        m_on = 0;
                    end else begin
                        m_lvl = !m_lvl;
                        if (m_lvl) begin m_rise = 1; m_rises++; end
                        else m_fall = 1;
                        if (had_pend > 0) m_half = m_pend.pop_front();
                        m_left = m_half;
                    end
                end
                if (u) begin
                    if (h == 0) m_err = 1;
                    else begin m_pend.delete(); m_pend.push_back(h); end
                end
                if (!m_on) m_pend.delete();
                if (p) m_dr = 1;
                m_rstn = m_on && (prev_rises >= RC);
            end
            exp = {m_lvl, m_rise, m_fall, m_on, m_rstn, m_err};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d got %b exp %b", cyc, obs(), exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div2_and_async_reset();
        test_period_update();
        test_stop();
        test_illegal_requests();
        test_short_run_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tvip_clock_enable_ctrl.md
Name: tvip_clock_enable_ctrl

Overview:
- Synthesizable controller that generates a programmable divided clock from the system clock, with start, stop and period-change control.
- Produces registered o_clk_div with rise/fall strobes, plus a sequenced downstream reset.
- Period changes and stops take effect only at half-period boundaries, so the generated waveform never glitches.
- Sits between test/config logic and clock-domain consumers in the tnoc environment.

Parameters:
COUNTER_WIDTH, 8, width of the half-period value and the internal down-counter, in i_clk cycles
RESET_CYCLES, 4, number of o_clk_div rising edges o_rst_n stays low after start (range 1..15)

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start request, sampled each cycle
i_stop  input  1  stop request, sampled each cycle
i_half_period  input  COUNTER_WIDTH  half period in i_clk cycles; 0 is illegal
i_period_update  input  1  sample i_half_period as pending new half period
o_clk_div  output  1  divided clock level, registered
o_rise  output  1  one-cycle pulse in the cycle o_clk_div becomes 1
o_fall  output  1  one-cycle pulse in the cycle o_clk_div becomes 0
o_running  output  1  high in RUN and DRAIN
o_rst_n  output  1  downstream active-low reset, registered
o_error  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, i_rst_n low):
  - State IDLE; counter 0; active and pending half period 0; pending-valid 0; reset counter 0.
  - Outputs: o_clk_div=0, o_rise=0, o_fall=0, o_running=0, o_rst_n=0, o_error=0.
  - Reset mid-operation aborts immediately; no drain.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - i_start=1, i_stop=0, i_half_period!=0: latch active=i_half_period, counter=i_half_period-1, go to RUN. o_clk_div stays 0.
  - i_start=1 with i_half_period==0: stay IDLE, o_error=1 next cycle.
  - i_start and i_stop both high: stop wins; nothing happens and no error.
  - i_period_update is ignored in IDLE.
- RUN:
  - Counter decrements each cycle.
  - At counter==0: toggle o_clk_div and assert o_rise or o_fall for that cycle.
  - On that same boundary, reload counter with pending-1 if pending-valid (then copy pending to active and clear pending-valid); otherwise reload with active-1.
  - Period of o_clk_div is 2*active i_clk cycles at 50% duty.
  - First rise occurs `active` cycles after entering RUN. Start high at edge T gives RUN at T+1 and o_clk_div=1 at T+1+active.
- Period update:
  - i_period_update=1 with nonzero value: pending=i_half_period, pending-valid=1.
  - A later update before the boundary overwrites the pending value (last wins).
  - Value 0: ignored, o_error pulse.
  - An update in the same cycle as a boundary is applied at the following boundary.
- i_start in RUN or DRAIN is ignored, with no error.
- i_stop in RUN: go to DRAIN; counting continues.
- DRAIN, at counter==0:
  - o_clk_div=1: toggle to 0, pulse o_fall, go to IDLE.
  - o_clk_div=0: go to IDLE without toggling.
  - The final low half period is always complete.
  - A pending update is discarded.
- Entering IDLE: o_running=0 and o_rst_n=0 in the same cycle.
- o_running=1 from the first cycle in RUN through the last DRAIN cycle.
- Downstream reset sequencing:
  - Reset counter cleared on entering RUN and incremented on each o_rise.
  - o_rst_n goes 1 in the cycle after the RESET_CYCLES-th rise and stays 1 until IDLE.
  - Stop before RESET_CYCLES rises: o_rst_n never deasserts.
- Arithmetic: counter is unsigned COUNTER_WIDTH. Maximum half period is 2^COUNTER_WIDTH-1; a value of 1 gives a toggle every cycle (divide by 2).

Test Plan:
- Reset with stimulus idle -> all outputs 0. Start with half=3 at edge T -> o_running=1 at T+1. o_clk_div rises at T+4 and falls at T+7, period 6. o_rise/o_fall are single-cycle pulses at those edges.
- half=1, RESET_CYCLES=4 -> o_clk_div toggles every cycle; o_rst_n=1 one cycle after the 4th o_rise. Assert i_rst_n=0 mid-run -> all outputs 0 immediately, state IDLE.
- Running with half=5, pulse update with 2 mid high phase -> current high phase lasts 5 cycles; subsequent phases last 2 cycles. Update with 0 -> o_error pulse, period unchanged.
- Stop while o_clk_div=1 with 2 cycles remaining -> o_fall after 2 cycles, then IDLE, o_rst_n=0. Stop while low -> low phase completes, no extra edge, IDLE.
- Start with half=0 -> o_error pulse, state remains IDLE. Start and stop in the same cycle -> no state change, no error. Start while running -> ignored.
- Start then stop after 2 rises with RESET_CYCLES=4 -> o_rst_n stays 0 throughout. Restart with half=255 -> first rise after 255 cycles.
